// File: rtl/tt_um_nefelimet_quad_decoder.sv
// Quadrature A/B encoder front-end: input synchroniser, glitch filter,
// Gray-code step decoder (x4 / x1) and a position accumulator.
// Optional feature: define QDEC_SATURATE_EN to saturate the position at
// 0 and 2^WIDTH-1 instead of wrapping modulo 2^WIDTH.
module tt_um_nefelimet_quad_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int WIDTH       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [3:0]       FILT_LAST = 4'(FILTER_LEN - 1);
   localparam logic [WIDTH-1:0] POS_MAX   = '1;

   // synchroniser chain carries {mode, clear, B, A}
   logic [3:0]       sync_q [SYNC_STAGES];
   logic [3:0]       sync_d [SYNC_STAGES];
   logic [1:0]       filt_q, filt_d;
   logic [1:0]       prev_q, prev_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] pos_q, pos_d;
   logic             dir_q, dir_d;
   logic             err_q, err_d;
   logic             up_q, up_d;
   logic             dn_q, dn_d;

   logic [1:0]       ab_s;
   logic             clr_s;
   logic             mode_s;
   logic             fwd, rev, illegal, step_up, step_dn;

   assign ab_s   = sync_q[SYNC_STAGES-1][1:0];
   assign clr_s  = sync_q[SYNC_STAGES-1][2];
   assign mode_s = sync_q[SYNC_STAGES-1][3];

   // shift the raw pins one stage further down the synchroniser each cycle
   always_comb begin
      sync_d[0] = ui_in[3:0];
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // glitch filter: accept a new AB only after FILTER_LEN consecutive differing cycles
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (ab_s != filt_q) begin
         if (cnt_q == FILT_LAST) begin
            filt_d = ab_s;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   // classify the accepted transition against the previous filtered AB
   always_comb begin
      fwd = 1'b0;
      rev = 1'b0;
      case ({prev_q, filt_q})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
         4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: rev = 1'b1;
         default: ;
      endcase
      illegal = ((prev_q ^ filt_q) == 2'b11);
      // x1 counts only the 10->00 (up) and 00->10 (down) edges of the cycle
      step_up = fwd & (~mode_s | (prev_q == 2'b10));
      step_dn = rev & (~mode_s | (prev_q == 2'b00));
      prev_d  = filt_q;
   end

   // position, direction, sticky error and one-cycle step pulses
   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      err_d = err_q;
      up_d  = 1'b0;
      dn_d  = 1'b0;
      if (clr_s) begin
         pos_d = '0;
         err_d = 1'b0;
      end else if (ena) begin
         if (illegal) begin
            err_d = 1'b1;
         end else if (step_up) begin
            up_d  = 1'b1;
            dir_d = 1'b1;
`ifdef QDEC_SATURATE_EN
            if (pos_q != POS_MAX) pos_d = pos_q + 1'b1;
`else
            pos_d = pos_q + 1'b1;
`endif
         end else if (step_dn) begin
            dn_d  = 1'b1;
            dir_d = 1'b0;
`ifdef QDEC_SATURATE_EN
            if (pos_q != '0) pos_d = pos_q - 1'b1;
`else
            pos_d = pos_q - 1'b1;
`endif
         end
      end
   end

   // state register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         filt_q <= '0;
         prev_q <= '0;
         cnt_q  <= '0;
         pos_q  <= '0;
         dir_q  <= 1'b0;
         err_q  <= 1'b0;
         up_q   <= 1'b0;
         dn_q   <= 1'b0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         filt_q <= filt_d;
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
         pos_q  <= pos_d;
         dir_q  <= dir_d;
         err_q  <= err_d;
         up_q   <= up_d;
         dn_q   <= dn_d;
      end
   end

   generate
      if (WIDTH >= 8) begin : g_out_wide
         assign uo_out = pos_q[7:0];
      end else begin : g_out_narrow
         assign uo_out = {{(8-WIDTH){1'b0}}, pos_q};
      end
   endgenerate

   assign uio_out = {4'b0000, err_q, dir_q, dn_q, up_q};
   assign uio_oe  = 8'h0F;

   logic unused_inputs;
   assign unused_inputs = &{1'b0, ui_in[7:4], uio_in};

endmodule

// File: tb/tb_tt_um_nefelimet_quad_decoder.sv
// Self-checking bench for tt_um_nefelimet_quad_decoder: directed test-plan
// steps followed by randomized pin activity, checked every cycle against a
// behavioural model built from pin history and Gray-index arithmetic.
module tb_tt_um_nefelimet_quad_decoder;

   localparam int SYNC_STAGES = 2;
   localparam int FILTER_LEN  = 3;
   localparam int WIDTH       = 8;
   localparam int POS_MOD     = 1 << WIDTH;
`ifdef QDEC_SATURATE_EN
   localparam int EXP_REV   = 0;
   localparam int EXP_DOWN3 = 0;
`else
   localparam int EXP_REV   = 255;
   localparam int EXP_DOWN3 = 253;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_checks = 0;
   int n_pass   = 0;
   int up_cnt   = 0;
   int dn_cnt   = 0;

   // behavioural model state
   logic [3:0] hist[$];
   logic [3:0] m_sync;
   logic [1:0] m_filt, m_prev;
   int         m_run;
   int         m_pos;
   logic       m_dir, m_err, m_up, m_dn;

   tt_um_nefelimet_quad_decoder #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .WIDTH      (WIDTH)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .uio_in (uio_in),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   always #5 clk = ~clk;

   function automatic int gidx(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] gval(input int i);
      case (i & 3)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function void m_reset();
      hist.delete();
      m_sync = 4'h0;
      m_filt = 2'b00;
      m_prev = 2'b00;
      m_run  = 0;
      m_pos  = 0;
      m_dir  = 1'b0;
      m_err  = 1'b0;
      m_up   = 1'b0;
      m_dn   = 1'b0;
   endfunction

   // advance the model by one rising edge using the pins present at that edge
   function void model_edge();
      int   d;
      int   step;
      logic clr, mode;
      clr  = m_sync[2];
      mode = m_sync[3];
      d    = (gidx(m_filt) - gidx(m_prev) + 4) % 4;   // 1 fwd, 3 rev, 2 illegal
      step = 0;
      if (d == 1 && (!mode || m_filt == 2'b00)) step = 1;
      if (d == 3 && (!mode || m_filt == 2'b10)) step = -1;
      m_up = 1'b0;
      m_dn = 1'b0;
      if (clr) begin
         m_pos = 0;
         m_err = 1'b0;
      end else if (ena) begin
         if (d == 2) begin
            m_err = 1'b1;
         end else if (step != 0) begin
            m_up  = (step > 0);
            m_dn  = (step < 0);
            m_dir = (step > 0);
`ifdef QDEC_SATURATE_EN
            m_pos = m_pos + step;
            if (m_pos > POS_MOD - 1) m_pos = POS_MOD - 1;
            if (m_pos < 0) m_pos = 0;
`else
            m_pos = (m_pos + step + POS_MOD) % POS_MOD;
`endif
         end
      end
      m_prev = m_filt;
      if (m_sync[1:0] != m_filt) begin
         m_run++;
         if (m_run == FILTER_LEN) begin
            m_filt = m_sync[1:0];
            m_run  = 0;
         end
      end else begin
         m_run = 0;
      end
      hist.push_back(ui_in[3:0]);
      if (hist.size() > SYNC_STAGES) void'(hist.pop_front());
      m_sync = (hist.size() == SYNC_STAGES) ? hist[0] : 4'h0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
   endtask

   // one clock: model on the rising edge, compare on the falling edge
   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      up_cnt += int'(uio_out[0]);
      dn_cnt += int'(uio_out[1]);
      chk("uo_out", 32'(uo_out), 32'(m_pos % 256));
      chk("uio_out", 32'(uio_out), 32'({4'b0000, m_err, m_dir, m_dn, m_up}));
      chk("uio_oe", 32'(uio_oe), 32'h0F);
   endtask

   task automatic hold(input logic [1:0] ab, input int n);
      ui_in[1:0] = ab;
      repeat (n) cyc();
   endtask

   task automatic clear_pulse();
      ui_in[2] = 1'b1;
      repeat (4) cyc();
      ui_in[2] = 1'b0;
      repeat (4) cyc();
   endtask

   initial begin
      logic [7:0] v;
      int         r;
      m_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_pos", 32'(uo_out), 32'd0);
      chk("reset_uio", 32'(uio_out), 32'd0);
      rst_n = 1'b1;
      $display("step: reset released");

      // four x4 forward cycles, first step exactly 6 edges after the A edge
      hold(2'b00, 8);
      up_cnt = 0;
      dn_cnt = 0;
      ui_in[1:0] = 2'b01;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         if (k == 5) chk("lat_before", 32'(uo_out), 32'd0);
         if (k == 6) begin
            chk("lat_pos", 32'(uo_out), 32'd1);
            chk("lat_up", 32'(uio_out[0]), 32'd1);
         end
         if (k == 7) chk("lat_pulse_len", 32'(uio_out[0]), 32'd0);
      end
      hold(2'b11, 8);
      hold(2'b10, 8);
      hold(2'b00, 8);
      for (int c = 0; c < 3; c++) begin
         hold(2'b01, 8); hold(2'b11, 8); hold(2'b10, 8); hold(2'b00, 8);
      end
      chk("fwd_pos", 32'(uo_out), 32'd16);
      chk("fwd_ups", 32'(up_cnt), 32'd16);
      chk("fwd_dir", 32'(uio_out[2]), 32'd1);
      chk("fwd_err", 32'(uio_out[3]), 32'd0);
      $display("step: x4 forward pos=%0d ups=%0d", uo_out, up_cnt);

      // 17 reverse steps
      dn_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         hold(2'b10, 8); hold(2'b11, 8); hold(2'b01, 8); hold(2'b00, 8);
      end
      hold(2'b10, 8);
      chk("rev_pos", 32'(uo_out), 32'(EXP_REV));
      chk("rev_downs", 32'(dn_cnt), 32'd17);
      chk("rev_dir", 32'(uio_out[2]), 32'd0);
      $display("step: x4 reverse pos=%0d downs=%0d", uo_out, dn_cnt);

      // back to 00 then clear; direction is held through clear
      hold(2'b00, 8);
      clear_pulse();
      chk("clr_pos", 32'(uo_out), 32'd0);
      chk("clr_dir", 32'(uio_out[2]), 32'd1);

      // glitch rejection: 2-clock pulse rejected, 3-clock pulse accepted
      up_cnt = 0;
      dn_cnt = 0;
      hold(2'b01, 2);
      hold(2'b00, 10);
      chk("glitch2_pos", 32'(uo_out), 32'd0);
      chk("glitch2_steps", 32'(up_cnt + dn_cnt), 32'd0);
      hold(2'b01, 3);
      hold(2'b00, 12);
      chk("glitch3_ups", 32'(up_cnt), 32'd1);
      chk("glitch3_downs", 32'(dn_cnt), 32'd1);
      chk("glitch3_pos", 32'(uo_out), 32'd0);
      $display("step: glitch ups=%0d downs=%0d", up_cnt, dn_cnt);

      // x1 mode: two forward cycles then one reverse cycle
      ui_in[3] = 1'b1;
      hold(2'b00, 4);
      up_cnt = 0;
      for (int c = 0; c < 2; c++) begin
         hold(2'b01, 8); hold(2'b11, 8); hold(2'b10, 8); hold(2'b00, 8);
      end
      chk("x1_fwd_pos", 32'(uo_out), 32'd2);
      chk("x1_fwd_ups", 32'(up_cnt), 32'd2);
      hold(2'b10, 8); hold(2'b11, 8); hold(2'b01, 8); hold(2'b00, 8);
      chk("x1_rev_pos", 32'(uo_out), 32'd1);
      ui_in[3] = 1'b0;
      hold(2'b00, 4);
      $display("step: x1 pos=%0d", uo_out);

      // illegal jump sets sticky error without a step
      hold(2'b11, 8);
      chk("illegal_err", 32'(uio_out[3]), 32'd1);
      chk("illegal_pos", 32'(uo_out), 32'd1);
      hold(2'b10, 8);
      hold(2'b00, 8);
      chk("sticky_err", 32'(uio_out[3]), 32'd1);
      chk("after_err_pos", 32'(uo_out), 32'd3);
      clear_pulse();
      chk("clr2_pos", 32'(uo_out), 32'd0);
      chk("clr2_err", 32'(uio_out[3]), 32'd0);
      $display("step: error and clear pos=%0d err=%0d", uo_out, uio_out[3]);

      // ena low freezes position; re-enable with static AB gives no step
      up_cnt = 0;
      dn_cnt = 0;
      ena = 1'b0;
      hold(2'b01, 8); hold(2'b11, 8); hold(2'b10, 8); hold(2'b00, 8); hold(2'b01, 8);
      ena = 1'b1;
      hold(2'b01, 10);
      chk("ena_pos", 32'(uo_out), 32'd0);
      chk("ena_steps", 32'(up_cnt + dn_cnt), 32'd0);

      // three down steps from 0: wrap, or stay at 0 when saturating
      dn_cnt = 0;
      hold(2'b00, 8); hold(2'b10, 8); hold(2'b11, 8);
      chk("down3_pos", 32'(uo_out), 32'(EXP_DOWN3));
      chk("down3_downs", 32'(dn_cnt), 32'd3);
      chk("down3_dir", 32'(uio_out[2]), 32'd0);
      $display("step: three downs pos=%0d downs=%0d", uo_out, dn_cnt);

      // reset mid-operation; first accepted AB decodes relative to 00
      hold(2'b01, 8);
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      chk("midrst_pos", 32'(uo_out), 32'd0);
      chk("midrst_uio", 32'(uio_out), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      hold(2'b01, 10);
      chk("postrst_pos", 32'(uo_out), 32'd1);
      chk("postrst_dir", 32'(uio_out[2]), 32'd1);
      chk("postrst_err", 32'(uio_out[3]), 32'd0);
      $display("step: mid-run reset pos=%0d", uo_out);

      // randomized pin activity checked every cycle against the model
      for (int t = 0; t < 1200; t++) begin
         v = ui_in;
         r = $urandom_range(0, 19);
         if (r < 11) v[1:0] = gval(gidx(v[1:0]) + (($urandom_range(0, 1) == 0) ? 1 : 3));
         else if (r == 11) v[1:0] = 2'($urandom_range(0, 3));
         else if (r == 12) v[3] = ~v[3];
         v[2]   = ($urandom_range(0, 24) == 0);
         v[7:4] = 4'($urandom_range(0, 15));
         ui_in  = v;
         uio_in = 8'($urandom_range(0, 255));
         ena    = ($urandom_range(0, 9) != 0);
         repeat ($urandom_range(1, 6)) cyc();
      end
      $display("step: random phase done pos=%0d", uo_out);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tt_um_nefelimet_quad_decoder.md
Name: tt_um_nefelimet_quad_decoder

Overview:
- Quadrature (A/B) encoder front-end: the producer side of the up/down count interface.
- Synchronises and glitch-filters the A/B pins, then decodes Gray-code transitions into one-cycle up/down step pulses.
- Accumulates the steps in a wrapping position register.
- Drops into the same Tiny Tapeout harness: standard tt_um pin set, one clock, async active-low reset.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser (minimum 2).
- FILTER_LEN, 3, number of consecutive cycles a synchronised A/B value must stay stable before it is accepted (1..15).
- WIDTH, 8, position counter width; only bits [7:0] drive uo_out.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; low freezes the position.
- ui_in  in  8  [0]=A, [1]=B, [2]=clear (active high), [3]=mode (0=x4, 1=x1), [7:4] unused.
- uo_out  out  8  position[7:0].
- uio_in  in  8  ignored.
- uio_out  out  8  [0]=up pulse, [1]=down pulse, [2]=direction (1=up, last valid step), [3]=sticky error, [7:4]=0.
- uio_oe  out  8  constant 8'h0F.

Behaviour:
- Reset (async assert, sync release):
  - position=0, direction=0, error=0, up/down pulses=0.
  - Synchroniser and filtered A/B = 2'b00; filter counter = 0.
- Synchroniser:
  - ui_in[3:0] pass through a SYNC_STAGES flop chain.
  - All control decisions use synchronised values only.
- Glitch filter:
  - Counter increments each cycle the synchronised AB differs from filtered AB; it resets to 0 whenever they are equal.
  - When the count reaches FILTER_LEN, filtered AB takes the synchronised value and the counter clears.
  - Pulses shorter than FILTER_LEN cycles after synchronisation are rejected.
- Decoder (state = previous filtered AB, Gray sequence 00->01->11->10->00):
  - Forward step = up; reverse step = down.
  - Both bits changing in one accepted update (00<->11, 01<->10) is illegal: set the sticky error, no step, state still takes the new value.
- Mode x4: every legal transition is a step.
- Mode x1: only 10->00 counts up and only 00->10 counts down; other legal transitions update state only.
- Step effect (registered, one cycle after the filtered update):
  - position += 1 or -= 1, modulo 2^WIDTH (255+1=0, 0-1=255).
  - Matching pulse on uio_out[0] or [1] high for exactly one cycle.
  - direction updated.
- Latency: A/B pin edge to uo_out change = SYNC_STAGES+FILTER_LEN+1 rising edges (6 at defaults). Benches check this exactly.
- Clear:
  - Synchronised clear high: position=0, error=0, pulses suppressed; direction held.
  - Clear has priority over a coincident step.
  - Decoder state keeps tracking the filtered AB while clear is high.
- ena low:
  - Position, direction, error and pulses hold; pulses are 0.
  - Synchroniser, filter and decoder state keep tracking, so re-enabling produces no spurious step.
  - Clear still acts while ena is low.
- Mode change takes effect on the next accepted transition. In-flight state is unaffected.
- Reset asserted mid-operation: all state is immediately at reset values. The first accepted AB after release is decoded relative to 00.

Optional Feature:
- Macro: QDEC_SATURATE_EN.
- Defined: position saturates. An up step at 2^WIDTH-1 or a down step at 0 leaves position unchanged, but the pulse and direction still update.
- Undefined: modulo wrap as described above.

Test Plan:
- Reset, then four x4 forward cycles of AB (00,01,11,10, each held 8 clocks) -> position=16, 16 up pulses, direction=1, error=0. First step appears exactly 6 edges after the A edge.
- From position 16, drive the reverse sequence for 17 steps in x4 -> position=255 (wrap), 17 down pulses, direction=0.
- A high for 2 clocks only (below FILTER_LEN after sync) -> no step, position unchanged; a 3-clock pulse -> one up step then one down step.
- Mode x1, two full forward cycles -> position +2; one full reverse cycle -> position -1.
- Jump AB 00->11 held 8 clocks -> error=1, position unchanged. Then clear pulse -> position=0, error=0.
- ena low during 5 forward steps, then ena high with AB static -> position unchanged, no pulses. With QDEC_SATURATE_EN defined, 3 down steps from 0 -> position stays 0, 3 down pulses.
